ov_dvp_capture: RTL and testbench



---
 rtl/ov_dvp_capture.sv | 181 ++++++++++++++++++
 tb/tb_ov_dvp_capture.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ov_dvp_capture.sv
// Camera-side frame buffer writer: assembles DVP RGB565 pixels, decimates DECIM x DECIM and
// emits 1-based linear write addresses (address 0 is reserved for "no pixel").
module ov_dvp_capture #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned DECIM       = 4,
    parameter int unsigned SKIP_FRAMES = 2,
    parameter int unsigned ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              wr_en,
    output logic [15:0]       wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              frame_start,
    output logic              frame_done,
    output logic              line_err
);
    localparam int unsigned X_W  = $clog2(H_ACTIVE + 1);
    localparam int unsigned Y_W  = $clog2(V_ACTIVE + 1);
    localparam int unsigned S_W  = $clog2(SKIP_FRAMES + 2);
    localparam int unsigned D_SH = $clog2(DECIM);

    localparam logic [X_W-1:0]    X_MAX     = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]    Y_MAX     = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0]    X_MASK    = X_W'(DECIM - 1);
    localparam logic [Y_W-1:0]    Y_MASK    = Y_W'(DECIM - 1);
    localparam logic [ADDR_W-1:0] ROW_PIX   = ADDR_W'(H_ACTIVE / DECIM);
    localparam logic [S_W-1:0]    SKIP_INIT = S_W'(SKIP_FRAMES);

    typedef enum logic [1:0] {StIdle, StSkip, StActive, StVblank} state_e;

    state_e            state_q, state_d;
    logic [S_W-1:0]    skip_q, skip_d;
    logic              start_d, done_d;

    logic              vs_q, hr_q, vs_prev, hr_prev;
    logic [7:0]        d_q;
    logic              vs_rise, vs_fall, hr_fall;

    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_q, hi_d;
    logic              wr_en_d, err_d;
    logic [15:0]       wr_data_d;
    logic [ADDR_W-1:0] wr_addr_d, pix_addr;

    assign vs_rise = vs_q & ~vs_prev;
    assign vs_fall = ~vs_q & vs_prev;
    assign hr_fall = ~hr_q & hr_prev;

    assign pix_addr = ADDR_W'(y_q >> D_SH) * ROW_PIX + ADDR_W'(x_q >> D_SH) + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A frame already running at reset is never captured: wait for its end.
                if (vs_rise) begin
                    state_d = StSkip;
                    skip_d  = SKIP_INIT;
                end
            end
            StSkip: begin
                if (vs_fall) begin
                    if (skip_q == '0) begin
                        state_d = StActive;
                        start_d = 1'b1;
                    end else begin
                        skip_d = skip_q - 1'b1;
                    end
                end
            end
            StActive: begin
                if (vs_rise) begin
                    state_d = StVblank;
                    done_d  = 1'b1;
                end
            end
            StVblank: begin
                if (vs_fall) begin
                    state_d = StActive;
                    start_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        phase_d   = phase_q;
        hi_d      = hi_q;
        err_d     = line_err;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data;
        wr_addr_d = wr_addr;
        if (start_d) begin
            x_d     = '0;
            y_d     = '0;
            phase_d = 1'b0;
        end else if (state_q == StActive) begin
            // Capture still runs in the cycle a vs_rise is seen, so a final byte is kept.
            if (hr_q) begin
                if (!phase_q) begin
                    hi_d    = d_q;
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (x_q < X_MAX) begin
                        x_d = x_q + 1'b1;
                    end
                    if ((x_q < X_MAX) && (y_q < Y_MAX) &&
                        ((x_q & X_MASK) == '0) && ((y_q & Y_MASK) == '0)) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = {hi_q, d_q};
                        wr_addr_d = pix_addr;
                    end
                end
            end else if (hr_fall) begin
                x_d = '0;
                if (y_q < Y_MAX) begin
                    y_d = y_q + 1'b1;
                end
                if (phase_q) begin
                    phase_d = 1'b0;
                    err_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_q        <= 1'b0;
            hr_q        <= 1'b0;
            d_q         <= '0;
            vs_prev     <= 1'b0;
            hr_prev     <= 1'b0;
            state_q     <= StIdle;
            skip_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            phase_q     <= 1'b0;
            hi_q        <= '0;
            wr_en       <= 1'b0;
            wr_data     <= '0;
            wr_addr     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
        end else begin
            vs_q        <= cam_vsync;
            hr_q        <= cam_href;
            d_q         <= cam_data;
            vs_prev     <= vs_q;
            hr_prev     <= hr_q;
            state_q     <= state_d;
            skip_q      <= skip_d;
            x_q         <= x_d;
            y_q         <= y_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            wr_en       <= wr_en_d;
            wr_data     <= wr_data_d;
            wr_addr     <= wr_addr_d;
            frame_start <= start_d;
            frame_done  <= done_d;
            line_err    <= err_d;
        end
    end

endmodule

// File: tb/tb_ov_dvp_capture.sv
// Scoreboard bench for ov_dvp_capture on a scaled 64x32 sensor (DECIM 4, two skipped frames).
module tb_ov_dvp_capture;
    localparam int unsigned H_ACTIVE    = 64;
    localparam int unsigned V_ACTIVE    = 32;
    localparam int unsigned DECIM       = 4;
    localparam int unsigned SKIP_FRAMES = 2;
    localparam int unsigned ADDR_W      = 15;
    localparam int unsigned FRAME_WR    = (H_ACTIVE / DECIM) * (V_ACTIVE / DECIM);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cam_vsync = 1'b0;
    logic              cam_href = 1'b0;
    logic [7:0]        cam_data = '0;
    logic              wr_en;
    logic [15:0]       wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              frame_start, frame_done, line_err;

    typedef struct {
        int unsigned addr;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   ncyc = 0;
    int   n_wr = 0;
    int   n_start = 0;
    int   n_done = 0;
    bit   prev_cap = 1'b0;

    always #5 clk = ~clk;

    ov_dvp_capture #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .DECIM      (DECIM),
        .SKIP_FRAMES(SKIP_FRAMES),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_addr    (wr_addr),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .line_err   (line_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Outputs are sampled 2 time units after the rising edge.
    always begin
        @(posedge clk);
        #2;
        if (reset) begin
            if (frame_start) n_start++;
            if (frame_done) n_done++;
            if (wr_en) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_wr", 32'(wr_en), 32'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    check_eq("wr_addr", 32'(wr_addr), mon_e.addr);
                    check_eq("wr_data", 32'(wr_data), 32'(mon_e.data));
                    check_eq("wr_time", ncyc, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] pix(input int x, input int y);
        if (x == 0 && y == 0) return 16'hF81F;
        return 16'(x * 263 + y * 71 + 16'h1234);
    endfunction

    task automatic step();
        @(negedge clk);
        ncyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            cam_href = 1'b0;
        end
    endtask

    task automatic vsync_pulse();
        for (int i = 0; i < 4; i++) begin
            step();
            cam_href  = 1'b0;
            cam_vsync = 1'b1;
        end
        for (int i = 0; i < 6; i++) begin
            step();
            cam_vsync = 1'b0;
        end
    endtask

    task automatic drive_bytes(input int y, input int nbytes, input bit cap);
        int          x;
        logic [15:0] p;
        for (int i = 0; i < nbytes; i++) begin
            x = i / 2;
            p = pix(x, y);
            step();
            cam_href = 1'b1;
            cam_data = (i % 2 == 0) ? p[15:8] : p[7:0];
            if (cap && (i % 2 == 1) && x < int'(H_ACTIVE) && y < int'(V_ACTIVE) &&
                (x % DECIM == 0) && (y % DECIM == 0)) begin
                exp_q.push_back('{addr: (y / DECIM) * (H_ACTIVE / DECIM) + x / DECIM + 1,
                                  data: p, cyc: ncyc + 1});
            end
        end
    endtask

    task automatic run_frame(input int nlines, input int npix, input int odd_y, input bit cap);
        int s0, d0, w0;
        s0 = n_start;
        d0 = n_done;
        w0 = n_wr;
        vsync_pulse();
        check_eq("frame_start_cnt", n_start - s0, 32'(cap));
        check_eq("frame_done_cnt", n_done - d0, 32'(prev_cap));
        for (int y = 0; y < nlines; y++) begin
            drive_bytes(y, 2 * npix - ((y == odd_y) ? 1 : 0), cap);
            idle(6);
        end
        check_eq("wr_count", n_wr - w0, cap ? FRAME_WR : 0);
        check_eq("queue_empty", exp_q.size(), 0);
        prev_cap = cap;
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_wr_en"}, 32'(wr_en), 0);
        check_eq({tag, "_wr_data"}, 32'(wr_data), 0);
        check_eq({tag, "_wr_addr"}, 32'(wr_addr), 0);
        check_eq({tag, "_frame_start"}, 32'(frame_start), 0);
        check_eq({tag, "_frame_done"}, 32'(frame_done), 0);
        check_eq({tag, "_line_err"}, 32'(line_err), 0);
    endtask

    initial begin
        int d0;
        #2;
        reset = 1'b0;
        idle(3);
        check_outputs_zero("reset");
        step();
        reset = 1'b1;
        idle(3);

        // Two skipped frames, then one captured full frame.
        run_frame(V_ACTIVE, H_ACTIVE, -1, 1'b0);
        run_frame(V_ACTIVE, H_ACTIVE, -1, 1'b0);
        run_frame(V_ACTIVE, H_ACTIVE, -1, 1'b1);
        check_eq("line_err_full", 32'(line_err), 0);

        run_frame(V_ACTIVE + 8, H_ACTIVE + 6, -1, 1'b1);
        check_eq("line_err_oversize", 32'(line_err), 0);

        run_frame(V_ACTIVE, H_ACTIVE, 3, 1'b1);
        check_eq("line_err_odd", 32'(line_err), 1);

        // Captured frame aborted by reset partway through row 4.
        d0 = n_done;
        vsync_pulse();
        check_eq("abort_frame_done", n_done - d0, 1);
        for (int y = 0; y < 4; y++) begin
            drive_bytes(y, 2 * H_ACTIVE, 1'b1);
            idle(6);
        end
        drive_bytes(4, 21, 1'b1);
        step();
        reset = 1'b0;
        @(posedge clk);
        #2;
        check_outputs_zero("midreset");
        exp_q.delete();
        cam_href = 1'b0;
        idle(3);
        step();
        reset = 1'b1;
        prev_cap = 1'b0;
        idle(3);

        run_frame(V_ACTIVE, H_ACTIVE, -1, 1'b0);
        run_frame(V_ACTIVE, H_ACTIVE, -1, 1'b0);
        run_frame(V_ACTIVE, H_ACTIVE, -1, 1'b1);
        d0 = n_done;
        vsync_pulse();
        check_eq("final_frame_done", n_done - d0, 1);
        check_eq("final_line_err", 32'(line_err), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
